multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Moore FSM that sequences a multi-cycle build of the MIPS datapath (PC, instruction/data memory, register bank, ALU, ALUControl). It replaces the single-cycle UnidadControl: it decodes op[5:0] once per instruction and drives the per-step enables and mux selects. It supports memory with a variable number of wait states through a req/ack handshake. The datapath keeps its mux, ALU and register-bank instances unchanged.

Parameters:
WAIT_MAX, 16, cycles a memory access may stay unacknowledged before a trap (1..255)
CNT_W, 32, width of the performance counters (only used under MC_PERF_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  instruction[31:26] taken from the IR
zero  in  1  ALU ZF
mem_ack  in  1  memory completed the current access this cycle
mem_read  out  1  memory read request, held until ack
mem_write  out  1  memory write request, held until ack
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  out  1  load the IR
pc_we  out  1  PC write enable (branch condition already resolved)
pc_source  out  2  PC mux select: 00 = ALU, 01 = ALUOut, 10 = jump target
reg_write  out  1  register bank write (RegEn)
reg_dst  out  1  write address: 0 = rt, 1 = rd
mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
alu_src_a  out  1  ALU A: 0 = PC, 1 = rs
alu_src_b  out  2  ALU B: 00 = rt, 01 = const 4, 10 = signext, 11 = signext<<2
alu_op  out  2  to ALUControl: 00 = add, 01 = sub, 10 = funct
state  out  4  current state, for debug
trap  out  1  sticky error flag

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EX=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, TRAP=15.
- Reset (asynchronous): state=FETCH, trap=0, wait counter=0. While rst_n=0 every output is 0.
- Outputs are decoded from state only. The exceptions are pc_we and ir_write, which are also gated by mem_ack (FETCH) and by zero (BRANCH). Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = pc_we = mem_ack.
  - Next state is DECODE when mem_ack=1; otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute the branch target). Next state by op:
  - 0x00 → R_EX
  - 0x23 (lw) or 0x2B (sw) → MEM_ADDR
  - 0x04 (beq) → BRANCH
  - 0x02 (j) → JUMP
  - 0x08 (addi) → ADDI_EX
  - any other op → TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Advance to MEM_WB on mem_ack.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next is FETCH.
- MEM_WR: mem_write=1, iord=1. Advance to FETCH on mem_ack.
- R_EX: alu_src_a=1, alu_src_b=00, alu_op=10. Next is R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_we=zero. Next is FETCH.
- JUMP: pc_source=10, pc_we=1. Next is FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next is ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next is FETCH.
- Latency in cycles with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle in a memory state adds 1.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ack=0.
  - When it reaches WAIT_MAX: next state is TRAP and trap is set.
  - mem_ack arriving in the same cycle the counter reaches WAIT_MAX completes the access; no trap.
- TRAP: all strobes 0, trap=1. Stays there until reset.
- mem_ack outside a memory state is ignored.
- Reset asserted mid-access: the request is dropped immediately. After release the FSM restarts at FETCH; the PC itself is reset by the datapath.

Optional Feature:
MC_PERF_EN
- Defined: adds outputs cycle_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0].
  - Both reset to 0.
  - cycle_cnt increments every cycle when not in TRAP.
  - instr_cnt increments on each transition into FETCH from any other state, i.e. at the last cycle of each instruction.
  - Both wrap modulo 2^CNT_W.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package mc_pkg holds:
  - the state enum (4-bit encodings above);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - ALUOp constants;
  - mux-select constants for alu_src_b and pc_source.
- One sub-module, mc_wait_timer: the wait counter and its timeout compare, cleared on state change.

Test Plan:
- Reset, then lw (op=0x23) with mem_ack=1 always → states 0,1,2,3,4,0. ir_write=1 and pc_we=1 in FETCH. reg_write=1 and mem_to_reg=1 only in state 4.
- R-type (op=0x00) with mem_ack held low 3 cycles in FETCH → FETCH lasts 4 cycles; ir_write and pc_we pulse only in the ack cycle; then 1,6,7,0 with alu_op=10 in R_EX.
- beq with zero=1, then beq with zero=0 → pc_we=1 with pc_source=01 in state 8 for the first; pc_we=0 for the second.
- op=0x3F → DECODE→TRAP, trap=1, all strobes 0. Stays in TRAP with mem_ack toggling; recovers to FETCH only after rst_n pulse.
- sw with mem_ack=0 for 16 cycles (WAIT_MAX=16) → TRAP. Repeat with ack on the 16th cycle → FETCH, no trap.
- With MC_PERF_EN defined, run j, addi, lw (zero wait states) → instr_cnt=3, cycle_cnt=12.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: state encoding, opcodes, mux selects and per-state control decode
// shared by the multi-cycle MIPS controller.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ack_strobe;     // ir_write and pc_we follow mem_ack
        logic       pc_we;
        logic       pc_we_on_zero;
        logic [1:0] pc_source;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read   = 1'b1;
                c.ack_strobe = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.pc_source  = PCSRC_ALU;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_R_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_RT;
                c.alu_op        = ALUOP_SUB;
                c.pc_source     = PCSRC_ALUOUT;
                c.pc_we_on_zero = 1'b1;
            end
            S_JUMP: begin
                c.pc_source = PCSRC_JUMP;
                c.pc_we     = 1'b1;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: req/ack memory handshake between controller (master)
// and the instruction/data memory (slave).
interface multicycle_ctrl_if;
    logic mem_read;
    logic mem_write;
    logic iord;
    logic mem_ack;

    modport master (
        output mem_read,
        output mem_write,
        output iord,
        input  mem_ack
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  iord,
        output mem_ack
    );
endinterface

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts unacknowledged memory cycles and flags the cycle in
// which the count would reach WAIT_MAX. Cleared whenever the FSM changes state.
module mc_wait_timer #(
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic timeout
);
    localparam logic [7:0] LAST = 8'(WAIT_MAX - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // an ack in the reaching cycle deasserts count, so it wins over the trap
    assign timeout = count && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing the multi-cycle MIPS datapath over a
// req/ack memory. Define MC_PERF_EN to add cycle_cnt/instr_cnt counters.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 16
`ifdef MC_PERF_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        op,
    input  logic              zero,
    multicycle_ctrl_if.master mem,
    output logic              ir_write,
    output logic              pc_we,
    output logic [1:0]        pc_source,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        alu_op,
    output logic [3:0]        state,
    output logic              trap
`ifdef MC_PERF_EN
    ,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt
`endif
);
    localparam ctrl_t CTRL_RESET = decode_ctrl(S_FETCH);

    state_t state_q, state_d;
    logic   trap_q, trap_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   in_mem_state, waiting, state_change, timeout;

    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                          (state_q == S_MEM_WR);
    assign waiting      = in_mem_state && !mem.mem_ack;
    assign state_change = (state_d != state_q);

    mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_change),
        .count  (waiting),
        .timeout(timeout)
    );

    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        case (state_q)
            S_FETCH: begin
                if (mem.mem_ack)  state_d = S_DECODE;
                else if (timeout) state_d = S_TRAP;
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_d = S_R_EX;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem.mem_ack)  state_d = S_MEM_WB;
                else if (timeout) state_d = S_TRAP;
            end
            S_MEM_WR: begin
                if (mem.mem_ack)  state_d = S_FETCH;
                else if (timeout) state_d = S_TRAP;
            end
            S_R_EX:    state_d = S_R_WB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
            default:   state_d = S_TRAP;
        endcase
        if (state_d == S_TRAP) trap_d = 1'b1;
        ctrl_d = decode_ctrl(state_d);
    end

    // control word is registered from the next state so it always matches state_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            trap_q  <= 1'b0;
            ctrl_q  <= CTRL_RESET;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign mem.mem_read  = rst_n & ctrl_q.mem_read;
    assign mem.mem_write = rst_n & ctrl_q.mem_write;
    assign mem.iord      = rst_n & ctrl_q.iord;
    assign ir_write      = rst_n & ctrl_q.ack_strobe & mem.mem_ack;
    assign pc_we         = rst_n & (ctrl_q.pc_we |
                                    (ctrl_q.ack_strobe & mem.mem_ack) |
                                    (ctrl_q.pc_we_on_zero & zero));
    assign pc_source     = rst_n ? ctrl_q.pc_source : '0;
    assign reg_write     = rst_n & ctrl_q.reg_write;
    assign reg_dst       = rst_n & ctrl_q.reg_dst;
    assign mem_to_reg    = rst_n & ctrl_q.mem_to_reg;
    assign alu_src_a     = rst_n & ctrl_q.alu_src_a;
    assign alu_src_b     = rst_n ? ctrl_q.alu_src_b : '0;
    assign alu_op        = rst_n ? ctrl_q.alu_op : '0;
    assign state         = rst_n ? 4'(state_q) : '0;
    assign trap          = rst_n & trap_q;

`ifdef MC_PERF_EN
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;

    always_comb begin
        cycle_d = cycle_q;
        instr_d = instr_q;
        if (state_q != S_TRAP) cycle_d = cycle_q + CNT_W'(1);
        if ((state_d == S_FETCH) && (state_q != S_FETCH)) instr_d = instr_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`endif

endmodule
